rx_dma_writer: RTL and testbench
================================

Name: rx_dma_writer

Overview:
- Device-side RX DMA write engine sitting directly upstream of the DB checker: it drives the checker's 128-bit AXI4 slave write port (s_axi_io_rx aw/w/b).
- It accepts one (address, byte length) command and a 128-bit data stream. It issues INCR write bursts that never cross a 4 KiB boundary, then reports a per-command completion status that includes any denial returned by the checker (SLVERR/DECERR).

Parameters:
- AXI_ID, 0, constant AWID driven on every burst (5 bits).
- MAX_BEATS, 16, maximum beats per burst (1..256).

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-low reset (reset==0 resets)
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
- cmd_addr  in  64  destination byte address
- cmd_len  in  24  transfer length in bytes
- s_data_valid  in  1  stream data valid
- s_data_ready  out  1  stream data accepted
- s_data_bits  in  128  stream payload, one beat
- m_axi_awid  out  5  = AXI_ID
- m_axi_awaddr  out  64  burst start address
- m_axi_awlen  out  8  beats-1
- m_axi_awsize  out  3  constant 3'b100 (16 B)
- m_axi_awburst  out  2  constant 2'b01 INCR
- m_axi_awcache  out  4  constant 4'b0011
- m_axi_awprot  out  3  constant 3'b000
- m_axi_awvalid  out  1
- m_axi_awready  in  1
- m_axi_wdata  out  128  = s_data_bits (pass-through)
- m_axi_wstrb  out  16  constant all ones
- m_axi_wlast  out  1  last beat of burst
- m_axi_wvalid  out  1
- m_axi_wready  in  1
- m_axi_bid  in  5  ignored
- m_axi_bresp  in  2
- m_axi_bvalid  in  1
- m_axi_bready  out  1
- sts_valid  out  1  completion valid
- sts_ready  in  1
- sts_resp  out  2  00 OKAY, else first non-OKAY bresp; 2'b11 also used for malformed command
- sts_beats  out  17  beats written for this command

Behaviour:
- Reset (reset==0 at clock edge):
  - state=IDLE.
  - Outputs cmd_ready=1, awvalid=0, wvalid=0, bready=0, sts_valid=0, s_data_ready=0.
  - sts_resp=0, sts_beats=0, awaddr=0, awlen=0.
  - Reset mid-operation abandons the command immediately; there is no completion and no drain.
- FSM states: IDLE, CALC, AW, W, B, STS.
- IDLE:
  - cmd_ready=1.
  - On accept, latch addr and beats_left=cmd_len[23:4], and clear err/resp/beat count.
  - If cmd_addr[3:0]!=0, cmd_len[3:0]!=0 or cmd_len==0, go to STS with sts_resp=2'b11 and sts_beats=0; no AXI traffic, no data consumed.
  - Otherwise go to CALC.
- CALC (1 cycle):
  - to_bound = 256 - addr[11:4] (9-bit).
  - burst = min(MAX_BEATS, beats_left, to_bound).
  - Register awaddr=addr and awlen=burst-1. Go to AW.
- AW:
  - awvalid=1, with address fields held stable until awready.
  - On handshake go to W.
  - W beats are not issued before the AW handshake.
- W:
  - wvalid = s_data_valid; s_data_ready = wready.
  - A beat transfers when s_data_valid&&wready.
  - wlast=1 when the burst beat counter == awlen.
  - On the last beat, addr += burst*16, beats_left -= burst, sts_beats += burst, then go to B.
- B:
  - bready=1.
  - On bvalid, if bresp!=00 and no error has been recorded yet, latch sts_resp=bresp.
  - The remaining bursts of the command are still issued so that the stream stays aligned.
  - Then go to CALC if beats_left!=0, else STS.
- STS:
  - sts_valid=1, held with stable sts_resp/sts_beats until sts_ready.
  - Then go to IDLE.
  - cmd_ready=0 in every state except IDLE.
- Concurrency: one burst outstanding; one command in flight.
- Address arithmetic: 64-bit, wraps modulo 2^64 without flagging.
- Burst sizing: a 4 KiB page end always terminates a burst. Maximum bursts per command = ceil(len/16/MAX_BEATS) + page crossings.
- s_data_valid asserted in non-W states is ignored (s_data_ready=0).

Test Plan:
- addr=0x1000, len=0x100 (16 beats), always-ready slave -> one AW (awaddr=0x1000, awlen=15), 16 W beats with wlast only on beat 16, then sts_resp=00, sts_beats=16.
- addr=0x1FC0, len=0x80 (8 beats) -> two bursts: 0x1FC0 awlen=3 and 0x2000 awlen=3; sts_beats=8.
- len=0x1000 with MAX_BEATS=16 -> 16 bursts at 0x100-byte stride; random wready/awready/bvalid stalls produce identical data ordering versus the input stream.
- The checker returns bresp=2'b10 on burst 2 of 3 and OKAY on burst 3 -> burst 3 is still issued; sts_resp=10, sts_beats=total beats.
- cmd_addr=0x1008 or cmd_len=0x18 or cmd_len=0 -> no awvalid, s_data_ready stays 0, sts_resp=11, sts_beats=0.
- reset=0 pulsed during the W state of burst 1 -> next cycle all valids are 0 and cmd_ready=1; a new command at 0x3000/len 0x10 completes with awlen=0 and sts_beats=1.

Source files
------------

// File: rtl/rx_dma_writer.sv
// RX DMA write engine: turns one (address, length) command plus a 128-bit stream
// into 4 KiB-safe AXI4 INCR write bursts and reports a per-command status.
module rx_dma_writer #(
  parameter logic [4:0] AXI_ID    = 5'd0,
  parameter int          MAX_BEATS = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [63:0]  cmd_addr,
  input  logic [23:0]  cmd_len,
  input  logic         s_data_valid,
  output logic         s_data_ready,
  input  logic [127:0] s_data_bits,
  output logic [4:0]   m_axi_awid,
  output logic [63:0]  m_axi_awaddr,
  output logic [7:0]   m_axi_awlen,
  output logic [2:0]   m_axi_awsize,
  output logic [1:0]   m_axi_awburst,
  output logic [3:0]   m_axi_awcache,
  output logic [2:0]   m_axi_awprot,
  output logic         m_axi_awvalid,
  input  logic         m_axi_awready,
  output logic [127:0] m_axi_wdata,
  output logic [15:0]  m_axi_wstrb,
  output logic         m_axi_wlast,
  output logic         m_axi_wvalid,
  input  logic         m_axi_wready,
  input  logic [4:0]   m_axi_bid,
  input  logic [1:0]   m_axi_bresp,
  input  logic         m_axi_bvalid,
  output logic         m_axi_bready,
  output logic         sts_valid,
  input  logic         sts_ready,
  output logic [1:0]   sts_resp,
  output logic [16:0]  sts_beats,
  output logic [2:0]   o_dbg_state
);

  // Every channel transfers on a cycle where valid && ready are both high at the
  // clock edge; a valid source holds its payload stable until that happens.

  typedef enum logic [2:0] {S_IDLE, S_CALC, S_AW, S_W, S_B, S_STS} state_t;

  localparam logic [19:0] MAX_B = 20'(MAX_BEATS);

  state_t       r_state, w_next;
  logic [63:0]  r_addr;
  logic [19:0]  r_beats_left;
  logic         r_err;
  logic [1:0]   r_sts_resp;
  logic [16:0]  r_sts_beats;
  logic [63:0]  r_awaddr;
  logic [7:0]   r_awlen;
  logic [8:0]   r_burst;
  logic [7:0]   r_beat_cnt;

  logic [8:0]   w_to_bound;
  logic [19:0]  w_min;
  logic [8:0]   w_burst;
  logic         w_bad;
  logic         w_beat;
  logic         w_last;

  assign w_bad  = (cmd_addr[3:0] != 4'd0) || (cmd_len[3:0] != 4'd0) || (cmd_len == 24'd0);
  assign w_last = (r_beat_cnt == r_awlen);
  assign w_beat = (r_state == S_W) && s_data_valid && m_axi_wready;

  // Burst = min(MAX_BEATS, beats left, beats up to the next 4 KiB page end).
  always_comb begin
    w_to_bound = 9'd256 - {1'b0, r_addr[11:4]};
    w_min      = MAX_B;
    if (r_beats_left < w_min)
      w_min = r_beats_left;
    if ({11'd0, w_to_bound} < w_min)
      w_min = {11'd0, w_to_bound};
    w_burst = w_min[8:0];
  end

  always_comb begin
    w_next        = r_state;
    cmd_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    s_data_ready  = 1'b0;
    m_axi_wlast   = 1'b0;
    m_axi_bready  = 1'b0;
    sts_valid     = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid)
          w_next = w_bad ? S_STS : S_CALC;
      end
      S_CALC: w_next = S_AW;
      S_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready)
          w_next = S_W;
      end
      S_W: begin
        m_axi_wvalid = s_data_valid;
        s_data_ready = m_axi_wready;
        m_axi_wlast  = w_last;
        if (w_beat && w_last)
          w_next = S_B;
      end
      S_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid)
          w_next = (r_beats_left != 20'd0) ? S_CALC : S_STS;
      end
      S_STS: begin
        sts_valid = 1'b1;
        if (sts_ready)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_beats_left <= '0;
      r_err        <= 1'b0;
      r_sts_resp   <= '0;
      r_sts_beats  <= '0;
      r_awaddr     <= '0;
      r_awlen      <= '0;
      r_burst      <= '0;
      r_beat_cnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_addr       <= cmd_addr;
            r_beats_left <= cmd_len[23:4];
            r_err        <= 1'b0;
            r_sts_beats  <= '0;
            r_sts_resp   <= w_bad ? 2'b11 : 2'b00;
          end
        end
        S_CALC: begin
          r_awaddr   <= r_addr;
          r_awlen    <= 8'(w_burst - 9'd1);
          r_burst    <= w_burst;
          r_beat_cnt <= '0;
        end
        S_W: begin
          if (w_beat) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
            if (w_last) begin
              r_addr       <= r_addr + {51'd0, r_burst, 4'd0};
              r_beats_left <= r_beats_left - {11'd0, r_burst};
              r_sts_beats  <= r_sts_beats + {8'd0, r_burst};
            end
          end
        end
        S_B: begin
          // Only the first denial is reported; later bursts still run to keep the stream aligned.
          if (m_axi_bvalid && (m_axi_bresp != 2'b00) && !r_err) begin
            r_err      <= 1'b1;
            r_sts_resp <= m_axi_bresp;
          end
        end
        default: ;
      endcase
    end
  end

  assign m_axi_awid    = AXI_ID;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awlen   = r_awlen;
  assign m_axi_awsize  = 3'b100;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wdata   = s_data_bits;
  assign m_axi_wstrb   = 16'hFFFF;
  assign sts_resp      = r_sts_resp;
  assign sts_beats     = r_sts_beats;
  assign o_dbg_state   = r_state;

  logic w_unused;
  assign w_unused = ^m_axi_bid;

endmodule

// File: tb/tb_rx_dma_writer.sv
// Bench for rx_dma_writer: random stream data and slave stalls, with expected
// AW/W/status traffic derived from the page/burst rules by a queue-based model.
module tb_rx_dma_writer;

  localparam int MAX_BEATS = 16;

  logic         clock, reset;
  logic         cmd_valid, cmd_ready;
  logic [63:0]  cmd_addr;
  logic [23:0]  cmd_len;
  logic         s_data_valid, s_data_ready;
  logic [127:0] s_data_bits;
  logic [4:0]   m_axi_awid;
  logic [63:0]  m_axi_awaddr;
  logic [7:0]   m_axi_awlen;
  logic [2:0]   m_axi_awsize;
  logic [1:0]   m_axi_awburst;
  logic [3:0]   m_axi_awcache;
  logic [2:0]   m_axi_awprot;
  logic         m_axi_awvalid, m_axi_awready;
  logic [127:0] m_axi_wdata;
  logic [15:0]  m_axi_wstrb;
  logic         m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [4:0]   m_axi_bid;
  logic [1:0]   m_axi_bresp;
  logic         m_axi_bvalid, m_axi_bready;
  logic         sts_valid, sts_ready;
  logic [1:0]   sts_resp;
  logic [16:0]  sts_beats;
  logic [2:0]   o_dbg_state;

  rx_dma_writer #(.AXI_ID(5'd0), .MAX_BEATS(MAX_BEATS)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .s_data_valid(s_data_valid), .s_data_ready(s_data_ready), .s_data_bits(s_data_bits),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awcache(m_axi_awcache),
    .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .sts_valid(sts_valid), .sts_ready(sts_ready), .sts_resp(sts_resp), .sts_beats(sts_beats),
    .o_dbg_state(o_dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // scoreboard state
  logic [71:0]  exp_aw_q[$];   // {awaddr, awlen}
  logic [128:0] exp_w_q[$];    // {wlast, wdata}
  logic [18:0]  exp_sts_q[$];  // {resp, beats}
  logic [127:0] src_q[$];
  logic [1:0]   b_plan_q[$];
  int checks = 0;
  int errors = 0;
  int sts_seen = 0;
  int w_total = 0;
  int b_pending = 0;
  bit aw_hs, w_hs, wl_hs, b_hs, s_hs, st_hs;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // monitor: decides handshakes at the negedge and compares against the queues
  always @(negedge clock) begin : monitor
    logic [71:0]  ea;
    logic [128:0] ew;
    logic [18:0]  es;
    aw_hs = 0; w_hs = 0; wl_hs = 0; b_hs = 0; s_hs = 0; st_hs = 0;
    if (reset) begin
      s_hs = s_data_valid && s_data_ready;
      b_hs = m_axi_bvalid && m_axi_bready;
      if (m_axi_awvalid && m_axi_awready) begin
        aw_hs = 1;
        if (exp_aw_q.size() == 0) chk("aw_unexpected", {m_axi_awaddr, m_axi_awlen}, 72'd0);
        else begin
          ea = exp_aw_q.pop_front();
          chk("aw_addr_len", {m_axi_awaddr, m_axi_awlen}, ea);
          chk("aw_const", {m_axi_awid, m_axi_awsize, m_axi_awburst, m_axi_awcache, m_axi_awprot},
              {5'd0, 3'b100, 2'b01, 4'b0011, 3'b000});
        end
      end
      if (m_axi_wvalid && m_axi_wready) begin
        w_hs = 1;
        wl_hs = m_axi_wlast;
        w_total++;
        if (exp_w_q.size() == 0) chk("w_unexpected", m_axi_wdata, 128'd0);
        else begin
          ew = exp_w_q.pop_front();
          chk("w_data", m_axi_wdata, ew[127:0]);
          chk("w_last", m_axi_wlast, ew[128]);
          chk("w_strb", m_axi_wstrb, 16'hFFFF);
        end
      end
      if (sts_valid && sts_ready) begin
        st_hs = 1;
        sts_seen++;
        if (exp_sts_q.size() == 0) chk("sts_unexpected", {sts_resp, sts_beats}, 19'd0);
        else begin
          es = exp_sts_q.pop_front();
          chk("sts_resp", sts_resp, es[18:17]);
          chk("sts_beats", sts_beats, es[16:0]);
        end
      end
    end
  end

  // stream source and AXI slave drivers with random stalls
  always @(posedge clock) begin
    #1;
    if (!reset) begin
      s_data_valid = 0; m_axi_bvalid = 0; m_axi_awready = 0; m_axi_wready = 0;
      sts_ready = 0; b_pending = 0;
    end else begin
      if (s_hs) void'(src_q.pop_front());
      if (!s_data_valid || s_hs) s_data_valid = (src_q.size() > 0) && ($urandom_range(0, 3) != 0);
      s_data_bits = (src_q.size() > 0) ? src_q[0] : '0;
      m_axi_awready = ($urandom_range(0, 2) != 0);
      m_axi_wready  = ($urandom_range(0, 3) != 0);
      sts_ready     = ($urandom_range(0, 1) != 0);
      if (wl_hs) b_pending++;
      if (b_hs) m_axi_bvalid = 0;
      if (!m_axi_bvalid && b_pending > 0 && $urandom_range(0, 2) == 0) begin
        m_axi_bvalid = 1;
        m_axi_bresp  = (b_plan_q.size() > 0) ? b_plan_q.pop_front() : 2'b00;
        m_axi_bid    = 5'($urandom);
        b_pending--;
      end
    end
  end

  // reference model: expected bursts, beats and status from the command rules
  task automatic issue(input logic [63:0] a, input logic [23:0] l, input int err_burst,
                       input logic [1:0] err_resp, input bit rand_err, input bit wait_sts);
    logic [63:0]  cur;
    logic [127:0] d;
    logic [1:0]   br, resp;
    int beats, room, n, total, idx, target, k;
    cur = a; resp = 2'b00; total = 0; idx = 0;
    if (a[3:0] != 0 || l[3:0] != 0 || l == 0) exp_sts_q.push_back({2'b11, 17'd0});
    else begin
      beats = int'(l) / 16;
      while (beats > 0) begin
        room = (4096 - int'(cur[11:0])) / 16;
        n = MAX_BEATS;
        if (beats < n) n = beats;
        if (room < n) n = room;
        exp_aw_q.push_back({cur, 8'(n - 1)});
        for (k = 0; k < n; k++) begin
          d = {$urandom, $urandom, $urandom, $urandom};
          src_q.push_back(d);
          exp_w_q.push_back({(k == n - 1), d});
        end
        br = 2'b00;
        if (idx == err_burst) br = err_resp;
        else if (rand_err && $urandom_range(0, 7) == 0) br = 2'($urandom_range(1, 3));
        b_plan_q.push_back(br);
        if (resp == 2'b00) resp = br;
        cur = cur + 64'(n * 16);
        beats -= n;
        total += n;
        idx++;
      end
      exp_sts_q.push_back({resp, 17'(total)});
    end
    target = sts_seen + 1;
    @(posedge clock); #2;
    cmd_valid = 1; cmd_addr = a; cmd_len = l;
    k = 0;
    do begin @(negedge clock); k++; end while (!cmd_ready && k < 1000);
    if (!cmd_ready) chk("cmd_accept_timeout", 0, 1);
    @(posedge clock); #2;
    cmd_valid = 0;
    if (wait_sts) begin
      k = 0;
      while (sts_seen < target && k < 8000) begin @(posedge clock); k++; end
      if (sts_seen < target) chk("sts_timeout", sts_seen, target);
    end
  endtask

  // main sequence
  initial begin
    int k;
    reset = 0; cmd_valid = 0; cmd_addr = '0; cmd_len = '0;
    s_data_valid = 0; s_data_bits = '0; m_axi_awready = 0; m_axi_wready = 0;
    m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 0; sts_ready = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_awvalid", m_axi_awvalid, 0);
    chk("rst_wvalid", m_axi_wvalid, 0);
    chk("rst_bready", m_axi_bready, 0);
    chk("rst_sts_valid", sts_valid, 0);
    chk("rst_s_data_ready", s_data_ready, 0);
    chk("rst_sts_resp", sts_resp, 0);
    chk("rst_sts_beats", sts_beats, 0);
    chk("rst_awaddr", m_axi_awaddr, 0);
    chk("rst_awlen", m_axi_awlen, 0);
    @(posedge clock); #2;
    reset = 1;

    issue(64'h1000, 24'h100, -1, 2'b00, 0, 1);
    issue(64'h1FC0, 24'h80, -1, 2'b00, 0, 1);
    issue(64'h0, 24'h1000, -1, 2'b00, 0, 1);
    issue(64'h5000, 24'h300, 1, 2'b10, 0, 1);
    issue(64'h1008, 24'h100, -1, 2'b00, 0, 1);
    issue(64'h1000, 24'h18, -1, 2'b00, 0, 1);
    issue(64'h1000, 24'h0, -1, 2'b00, 0, 1);
    issue(64'hFFFF_FFFF_FFFF_FFE0, 24'h40, -1, 2'b00, 0, 1);
    for (int i = 0; i < 8; i++) begin
      logic [11:0] off;
      off = ($urandom_range(0, 1) != 0) ? 12'(4096 - 16 * $urandom_range(1, 8))
                                        : 12'(16 * $urandom_range(0, 255));
      issue({$urandom, 20'($urandom), off}, 24'(16 * $urandom_range(1, 64)), -1, 2'b00, 1, 1);
    end

    // reset in the middle of the first burst's data phase
    issue(64'h1000, 24'h100, -1, 2'b00, 0, 0);
    k = 0;
    while (w_total < 3 + 0 && k < 0) k++;
    begin
      int start;
      start = w_total;
      k = 0;
      while (w_total < start + 3 && k < 2000) begin @(posedge clock); k++; end
      if (w_total < start + 3) chk("mid_w_timeout", w_total, start + 3);
    end
    #2;
    reset = 0;
    exp_aw_q.delete(); exp_w_q.delete(); exp_sts_q.delete(); src_q.delete(); b_plan_q.delete();
    @(posedge clock); #2;
    reset = 1;
    @(negedge clock);
    chk("mid_rst_cmd_ready", cmd_ready, 1);
    chk("mid_rst_awvalid", m_axi_awvalid, 0);
    chk("mid_rst_wvalid", m_axi_wvalid, 0);
    chk("mid_rst_bready", m_axi_bready, 0);
    chk("mid_rst_sts_valid", sts_valid, 0);
    chk("mid_rst_s_data_ready", s_data_ready, 0);
    issue(64'h3000, 24'h10, -1, 2'b00, 0, 1);

    repeat (5) @(posedge clock);
    chk("aw_q_drained", exp_aw_q.size(), 0);
    chk("w_q_drained", exp_w_q.size(), 0);
    chk("sts_q_drained", exp_sts_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
